// File: rtl/csr_pkg.sv
// Shared types, address map and helpers for the Zicntr/Zihpm counter file.
package csr_pkg;

  typedef enum logic [1:0] {
    CsrOpIllegal = 2'b00,
    CsrOpRw      = 2'b01,
    CsrOpRs      = 2'b10,
    CsrOpRc      = 2'b11
  } csr_op_t;

  localparam logic [11:0] CSR_MCYCLE        = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET      = 12'hB02;
  localparam logic [11:0] CSR_MHPM_BASE     = 12'hB03;
  localparam logic [11:0] CSR_HIGH_OFS      = 12'h080;
  localparam logic [11:0] CSR_USER_OFS      = 12'h100;
  localparam logic [11:0] CSR_MCOUNTINHIBIT = 12'h320;

  localparam int unsigned INH_CY       = 0;
  localparam int unsigned INH_IR       = 2;
  localparam int unsigned INH_HPM_BASE = 3;

  function automatic logic [31:0] inhibit_mask(input int unsigned num_hpm);
    logic [31:0] m;
    m = '0;
    m[INH_CY] = 1'b1;
    m[INH_IR] = 1'b1;
    for (int unsigned i = 0; i < 29; i++) begin
      if (i < num_hpm) m[INH_HPM_BASE + i] = 1'b1;
    end
    return m;
  endfunction

  function automatic logic [31:0] csr_apply(input csr_op_t op, input logic [31:0] old,
                                            input logic [31:0] wdata);
    logic [31:0] res;
    case (op)
      CsrOpRw: res = wdata;
      CsrOpRs: res = old | wdata;
      CsrOpRc: res = old & ~wdata;
      default: res = old;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/csr_counter.sv
// One free-running counter with 32-bit half writes; a write wins over the same-cycle increment.
module csr_counter #(
  parameter int unsigned CNT_W = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             inhibit,
  input  logic             wr_lo,
  input  logic             wr_hi,
  input  logic [31:0]      wdata,
  output logic [CNT_W-1:0] value
);

  logic [CNT_W-1:0] value_q, value_d;

  always_comb begin
    value_d = value_q;
    if (wr_lo) begin
      value_d = {value_q[CNT_W-1:32], wdata};
    end else if (wr_hi) begin
      // Bits of wdata beyond CNT_W-32 fall off in the truncating cast.
      value_d = CNT_W'({wdata, value_q[31:0]});
    end else if (inc && !inhibit) begin
      value_d = value_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) value_q <= '0;
    else      value_q <= value_d;
  end

  assign value = value_q;

endmodule

// File: rtl/csr_counter_unit.sv
// Counter CSR file: mcycle, minstret, NUM_HPM event counters and mcountinhibit with
// registered read response one cycle after the request.
module csr_counter_unit
  import csr_pkg::*;
#(
  parameter int unsigned NUM_HPM = 4,
  parameter int unsigned CNT_W   = 64
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   csr_valid,
  input  csr_op_t                                csr_op,
  input  logic [11:0]                            csr_addr,
  input  logic [31:0]                            csr_wdata,
  input  logic                                   csr_wr_en,
  input  logic                                   retire,
  input  logic [((NUM_HPM > 0) ? NUM_HPM : 1)-1:0] hpm_event,
  output logic                                   csr_rvalid,
  output logic [31:0]                            csr_rdata,
  output logic                                   csr_illegal
);

  localparam int unsigned NUM_CNT  = 2 + NUM_HPM;
  localparam int unsigned SLOT_W   = $clog2(NUM_CNT);
  localparam logic [31:0] INH_MASK = inhibit_mask(NUM_HPM);

  logic [63:0]       cnt_ext [NUM_CNT];
  logic [31:0]       inh_q, inh_d;
  logic [11:0]       addr_base;
  logic              is_mach, is_user, sel_inh, sel_hi, legal, do_wr;
  logic [4:0]        idx_raw;
  logic [SLOT_W-1:0] slot;
  logic [31:0]       old_half, new_half;
  logic              rvalid_q, illegal_q;
  logic [31:0]       rdata_q;

  // Strip the high-half bit and the counter index to find the counter bank.
  assign addr_base = csr_addr & ~(CSR_HIGH_OFS | 12'h01F);
  assign is_mach   = (addr_base == CSR_MCYCLE);
  assign is_user   = (addr_base == (CSR_MCYCLE + CSR_USER_OFS));
  assign idx_raw   = csr_addr[4:0];
  assign sel_hi    = csr_addr[7];
  assign sel_inh   = (csr_addr == CSR_MCOUNTINHIBIT);

  always_comb begin
    slot  = '0;
    legal = 1'b0;
    if (sel_inh) begin
      legal = 1'b1;
    end else if (is_mach || is_user) begin
      if (idx_raw == CSR_MCYCLE[4:0]) begin
        legal = 1'b1;
      end else if (idx_raw == CSR_MINSTRET[4:0]) begin
        slot  = SLOT_W'(1);
        legal = 1'b1;
      end else if (idx_raw >= CSR_MHPM_BASE[4:0] &&
                   int'(idx_raw) < int'(CSR_MHPM_BASE[4:0]) + int'(NUM_HPM)) begin
        // hpm index 3+i lands in slot 2+i.
        slot  = SLOT_W'(idx_raw - 5'd1);
        legal = 1'b1;
      end
    end
    if (csr_op == CsrOpIllegal || (is_user && csr_wr_en)) legal = 1'b0;
  end

  assign do_wr = csr_valid && legal && csr_wr_en;

  always_comb begin
    old_half = '0;
    if (sel_inh) begin
      old_half = inh_q;
    end else begin
      for (int k = 0; k < int'(NUM_CNT); k++) begin
        if (slot == SLOT_W'(k)) old_half = sel_hi ? cnt_ext[k][63:32] : cnt_ext[k][31:0];
      end
    end
  end

  assign new_half = csr_apply(csr_op, old_half, csr_wdata);

  for (genvar k = 0; k < int'(NUM_CNT); k++) begin : g_cnt
    logic             inc, inh, wr_lo, wr_hi;
    logic [CNT_W-1:0] value;

    if (k == 0) begin : g_cycle
      assign inc = 1'b1;
      assign inh = inh_q[INH_CY];
    end else if (k == 1) begin : g_instret
      assign inc = retire;
      assign inh = inh_q[INH_IR];
    end else begin : g_hpm
      assign inc = hpm_event[k-2];
      assign inh = inh_q[INH_HPM_BASE + k - 2];
    end

    assign wr_lo = do_wr && !sel_inh && !sel_hi && (slot == SLOT_W'(k));
    assign wr_hi = do_wr && !sel_inh && sel_hi && (slot == SLOT_W'(k));

    csr_counter #(
      .CNT_W (CNT_W)
    ) u_cnt (
      .clk     (clk),
      .rst     (rst),
      .inc     (inc),
      .inhibit (inh),
      .wr_lo   (wr_lo),
      .wr_hi   (wr_hi),
      .wdata   (new_half),
      .value   (value)
    );

    assign cnt_ext[k] = 64'(value);
  end

  always_comb begin
    inh_d = inh_q;
    if (do_wr && sel_inh) inh_d = new_half & INH_MASK;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inh_q     <= '0;
      rvalid_q  <= 1'b0;
      illegal_q <= 1'b0;
      rdata_q   <= '0;
    end else begin
      inh_q     <= inh_d;
      rvalid_q  <= csr_valid;
      illegal_q <= csr_valid && !legal;
      rdata_q   <= (csr_valid && legal) ? old_half : '0;
    end
  end

  assign csr_rvalid  = rvalid_q;
  assign csr_rdata   = rdata_q;
  assign csr_illegal = illegal_q;

endmodule

// File: doc/csr_counter_unit.md
Name: csr_counter_unit

Overview:
- Parametrised successor to the core's fixed cycle/instret CSR block.
- Implements the Zicntr/Zihpm counter file: mcycle, minstret and NUM_HPM event counters of width CNT_W, plus mcountinhibit.
- Supports CSRRW/CSRRS/CSRRC writes to the machine-level aliases and read-only user-level shadows.
- Sits beside EX. Takes decoded CSR requests, retire pulses and event pulses, and returns registered read data one cycle later.

Parameters:
- NUM_HPM, 4, number of mhpmcounterN (N = 3..3+NUM_HPM-1); legal range 0..29.
- CNT_W, 64, counter width; legal range 33..64. Bits at and above CNT_W read 0 and ignore writes.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous, active-low reset
- csr_valid  in  1  CSR instruction in EX this cycle
- csr_op  in  2  csr_op_t: 01=RW, 10=RS, 11=RC; 00 illegal
- csr_addr  in  12  CSR address
- csr_wdata  in  32  resolved source operand (rs1 value or zimm)
- csr_wr_en  in  1  0 when RS/RC source is x0/zimm 0, i.e. no write side effect
- retire  in  1  one instruction committed this cycle
- hpm_event  in  NUM_HPM  per-counter event pulse; bit i drives mhpmcounter(3+i)
- csr_rvalid  out  1  registered; high the cycle after csr_valid
- csr_rdata  out  32  registered read data (old value)
- csr_illegal  out  1  registered; qualifies csr_rvalid

Behaviour:
- Reset (rst=0, async): all counters = 0; mcountinhibit = 0; csr_rvalid = 0; csr_rdata = 0; csr_illegal = 0.
- Address map:
  - mcycle B00 / mcycleh B80
  - minstret B02 / minstreth B82
  - mhpmcounterN B00+N / B80+N
  - user shadows: cycle C00/C80, instret C02/C82, hpmcounterN C00+N/C80+N
  - mcountinhibit 320: bits 0, 2 and 3..3+NUM_HPM-1 are writable; all other bits read 0.
  - time (C01/C81) and any unmapped address are illegal.
- Increment, per counter every cycle when its inhibit bit is 0:
  - mcycle += 1 unconditionally.
  - minstret += retire.
  - hpm i += hpm_event[i].
  - Wrap-around: 2^CNT_W-1 -> 0. No overflow flag.
- Read: csr_rdata = the addressed 32-bit half of the value held before this edge, so an increment on the same edge is not visible.
  - High half = bits [63:32], zero-extended above CNT_W.
- Write: new = RW ? wdata : RS ? old|wdata : old&~wdata, applied to the addressed half only. The other half is unchanged.
  - Write takes priority over the same-cycle increment; that increment is discarded for that counter.
  - Writes to mcountinhibit take effect from the next cycle.
- Illegal, registered next cycle (csr_illegal=1, csr_rdata=0, no state change):
  - unmapped address, or csr_op=00;
  - write (csr_wr_en=1) to a C-range shadow;
  - hpm index >= NUM_HPM.
- RS/RC with csr_wr_en=0 is a pure read and is legal on shadows.
- Back-to-back: csr_valid may assert every cycle. Each request is answered exactly one cycle later, with no stall and no queue.
- Reset mid-operation: a pending response is dropped; csr_rvalid=0 immediately (asynchronous).

Decomposition:
- csr_pkg:
  - csr_op_t enum;
  - address constants: CSR_MCYCLE, CSR_MINSTRET, CSR_MHPM_BASE, CSR_HIGH_OFS (0x80), CSR_USER_OFS (0x100), CSR_MCOUNTINHIBIT;
  - inhibit bit positions.
- Sub-module csr_counter (parameter CNT_W):
  - inputs: inc, inhibit, wr_lo, wr_hi, wdata[31:0];
  - output: value[CNT_W-1:0];
  - instantiated 2+NUM_HPM times via generate.

Test Plan:
- Release reset, idle 10 cycles, read C00 -> csr_rvalid one cycle later, rdata = cycle count at sample edge (10 ± 0 by bench model). Read C80 -> 0.
- Write mcycle = FFFF_FFFF via RW B00, then read B80 two cycles later -> 1 (carry across halves). With CNT_W=40, write B80 = FFFF_FFFF -> read back 0000_00FF.
- Set mcountinhibit bit 2 (RS 320, wdata=4), pulse retire 5 times, read B02 -> unchanged. Clear the bit, retire 3 times -> +3.
- Write B02 = 100 in the same cycle retire=1 -> next read 100, not 101.
- RW to C00 with csr_wr_en=1 -> csr_illegal=1, rdata=0, cycle unaffected. RS to C00 with csr_wr_en=0 -> legal read.
- NUM_HPM=2: pulse hpm_event[1] 7 times, read B04 -> 7. Read B05 -> illegal. Preload B03 low half = FFFF_FFFF, high = FFFF_FFFF (CNT_W=64), one event -> both halves 0.
